// File: rtl/mda_motor_control_ramp_sched_pkg.sv
// Shared definitions for the motor ramp scheduler.
// Contents:
//   PERIOD_LENGTH - width of period/duty/target words
//   DWELL_W       - width of the per-motor dwell counter
//   scan_state_e  - scan FSM states (IDLE / RD / UPD)
//   ramp_sign_e   - position of a duty value relative to the brake point
//   side_of()     - classifies a duty value against the brake point
package mda_motor_control_ramp_sched_pkg;

    localparam int PERIOD_LENGTH = 16;
    localparam int DWELL_W       = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RD   = 2'b01,
        ST_UPD  = 2'b10
    } scan_state_e;

    typedef enum logic [1:0] {
        SIGN_ZERO = 2'b00,
        SIGN_POS  = 2'b01,
        SIGN_NEG  = 2'b11
    } ramp_sign_e;

    function automatic ramp_sign_e side_of(input logic [PERIOD_LENGTH-1:0] x,
                                           input logic [PERIOD_LENGTH-1:0] half);
        if (x > half)
            return SIGN_POS;
        else if (x < half)
            return SIGN_NEG;
        else
            return SIGN_ZERO;
    endfunction

endpackage

// File: rtl/mda_motor_control_ramp_sched_ramp_step.sv
// Combinational ramp-step datapath shared by all motors.
// Given one motor's on state, current duty, target, dwell count and the
// shared period/step/dwell settings, produces that motor's next duty and
// next dwell count for one ramp tick.
// Ports:
//   on          in   1    motor on state
//   cur         in   16   current duty
//   tgt         in   16   target duty
//   half        in   16   brake point (period >> 1)
//   period      in   16   shared PWM period
//   step        in   16   max duty change per tick
//   dwell       in   8    remaining dwell ticks
//   dwell_ticks in   8    dwell reload on reaching the brake point
//   next_cur    out  16   updated duty
//   next_dwell  out  8    updated dwell count
module mda_motor_control_ramp_sched_ramp_step
    import mda_motor_control_ramp_sched_pkg::*;
(
    input  logic                     on,
    input  logic [PERIOD_LENGTH-1:0] cur,
    input  logic [PERIOD_LENGTH-1:0] tgt,
    input  logic [PERIOD_LENGTH-1:0] half,
    input  logic [PERIOD_LENGTH-1:0] period,
    input  logic [PERIOD_LENGTH-1:0] step,
    input  logic [DWELL_W-1:0]       dwell,
    input  logic [DWELL_W-1:0]       dwell_ticks,
    output logic [PERIOD_LENGTH-1:0] next_cur,
    output logic [DWELL_W-1:0]       next_dwell
);

    ramp_sign_e cur_side;
    ramp_sign_e tgt_side;
    logic       reversal;

    logic [PERIOD_LENGTH-1:0] half_diff;
    logic [PERIOD_LENGTH-1:0] half_move;
    logic [PERIOD_LENGTH-1:0] half_next;
    logic [PERIOD_LENGTH-1:0] tgt_diff;
    logic [PERIOD_LENGTH-1:0] tgt_move;
    logic [PERIOD_LENGTH-1:0] tgt_next;

    assign cur_side = side_of(cur, half);
    assign tgt_side = side_of(tgt, half);

    // Opposite sides of the brake point means the motor must pass through half.
    assign reversal = ((cur_side == SIGN_POS) && (tgt_side == SIGN_NEG)) ||
                      ((cur_side == SIGN_NEG) && (tgt_side == SIGN_POS));

    // Differences are always larger-minus-smaller and the move is capped at
    // the difference, so neither path can wrap or overshoot.
    assign half_diff = (cur > half) ? (cur - half) : (half - cur);
    assign half_move = (step < half_diff) ? step : half_diff;
    assign half_next = (cur > half) ? (cur - half_move) : (cur + half_move);

    assign tgt_diff  = (cur > tgt) ? (cur - tgt) : (tgt - cur);
    assign tgt_move  = (step < tgt_diff) ? step : tgt_diff;
    assign tgt_next  = (cur > tgt) ? (cur - tgt_move) : (cur + tgt_move);

    always_comb begin
        next_cur   = cur;
        next_dwell = dwell;
        if (!on) begin
            next_cur   = half;
            next_dwell = '0;
        end else if (cur > period) begin
            next_cur = period;
        end else if (dwell != '0) begin
            next_dwell = dwell - DWELL_W'(1);
        end else if (reversal) begin
            next_cur = half_next;
            if (half_next == half)
                next_dwell = dwell_ticks;
        end else begin
            next_cur = tgt_next;
        end
    end

endmodule

// File: rtl/mda_motor_control_ramp_sched.sv
// Slew-rate scheduler for the per-motor H-bridge PWM generators.
// Holds a target and current duty per motor; on every ramp tick it walks
// all motors through one shared ramp-step datapath (2 cycles per motor).
// Ports:
//   clk          in   1          system clock
//   reset        in   1          synchronous active-high reset
//   period       in   16         shared PWM period; half is the brake point
//   step         in   16         max duty change per motor per tick
//   dwell_ticks  in   8          ticks held at half on a direction reversal
//   wr_en        in   1          one-cycle command strobe
//   wr_addr      in   ADDR_W     motor index
//   wr_data      in   16         new target duty
//   wr_on        in   1          new on state
//   duty_out     out  16*N       current duty, motor i at [16*i+15:16*i]
//   on_out       out  N          per-motor on state
//   busy         out  1          high while a scan is in progress
module mda_motor_control_ramp_sched
    import mda_motor_control_ramp_sched_pkg::*;
#(
    parameter  int NUM_MOTORS = 8,
    parameter  int TICK_DIV   = 16000,
    localparam int ADDR_W     = (NUM_MOTORS > 1) ? $clog2(NUM_MOTORS) : 1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [PERIOD_LENGTH-1:0]            period,
    input  logic [PERIOD_LENGTH-1:0]            step,
    input  logic [DWELL_W-1:0]                  dwell_ticks,
    input  logic                                wr_en,
    input  logic [ADDR_W-1:0]                   wr_addr,
    input  logic [PERIOD_LENGTH-1:0]            wr_data,
    input  logic                                wr_on,
    output logic [PERIOD_LENGTH*NUM_MOTORS-1:0] duty_out,
    output logic [NUM_MOTORS-1:0]               on_out,
    output logic                                busy
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_MOTORS - 1);

    logic [PERIOD_LENGTH-1:0] cur_mem   [NUM_MOTORS];
    logic [PERIOD_LENGTH-1:0] tgt_mem   [NUM_MOTORS];
    logic [DWELL_W-1:0]       dwell_mem [NUM_MOTORS];

    logic [CNT_W-1:0]  tick_cnt;
    logic              tick;
    logic              tick_pend;
    logic              pend_d;
    scan_state_e       state_q;
    scan_state_e       state_d;
    logic [ADDR_W-1:0] idx_q;
    logic [ADDR_W-1:0] idx_d;

    logic [PERIOD_LENGTH-1:0] lat_tgt;
    logic [PERIOD_LENGTH-1:0] lat_cur;
    logic [DWELL_W-1:0]       lat_dwell;
    logic [PERIOD_LENGTH-1:0] half;
    logic [PERIOD_LENGTH-1:0] wr_tgt;
    logic [PERIOD_LENGTH-1:0] upd_cur;
    logic [DWELL_W-1:0]       upd_dwell;
    logic                     wr_addr_ok;
    logic                     upd_blocked;

    assign half        = period >> 1;
    assign wr_tgt      = (wr_data > period) ? period : wr_data;
    assign wr_addr_ok  = (int'(wr_addr) < NUM_MOTORS);
    // A same-cycle write to the motor being updated takes precedence.
    assign upd_blocked = wr_en && wr_addr_ok && (wr_addr == idx_q);
    assign tick        = (tick_cnt == CNT_W'(TICK_DIV - 1));
    assign busy        = (state_q != ST_IDLE);

    for (genvar g = 0; g < NUM_MOTORS; g++) begin : g_duty
        assign duty_out[PERIOD_LENGTH*g +: PERIOD_LENGTH] = cur_mem[g];
    end

    mda_motor_control_ramp_sched_ramp_step u_ramp_step (
        .on          (on_out[idx_q]),
        .cur         (lat_cur),
        .tgt         (lat_tgt),
        .half        (half),
        .period      (period),
        .step        (step),
        .dwell       (lat_dwell),
        .dwell_ticks (dwell_ticks),
        .next_cur    (upd_cur),
        .next_dwell  (upd_dwell)
    );

    // Free-running tick divider; the tick pulse is the wrap cycle.
    always_ff @(posedge clk) begin
        if (reset)
            tick_cnt <= '0;
        else if (tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + CNT_W'(1);
    end

    // Scan sequencing; a tick arriving mid-scan is remembered once and
    // starts the next scan as soon as the current one returns to IDLE.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pend_d  = tick_pend;
        case (state_q)
            ST_IDLE: begin
                if (tick || tick_pend) begin
                    state_d = ST_RD;
                    idx_d   = '0;
                    pend_d  = 1'b0;
                end
            end
            ST_RD: begin
                state_d = ST_UPD;
                if (tick)
                    pend_d = 1'b1;
            end
            ST_UPD: begin
                if (tick)
                    pend_d = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RD;
                    idx_d   = idx_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            tick_pend <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            tick_pend <= pend_d;
        end
    end

    // RD snapshots the motor's state so UPD sees a stable operand set.
    always_ff @(posedge clk) begin
        if (reset) begin
            lat_tgt   <= '0;
            lat_cur   <= '0;
            lat_dwell <= '0;
        end else if (state_q == ST_RD) begin
            lat_tgt   <= tgt_mem[idx_q];
            lat_cur   <= cur_mem[idx_q];
            lat_dwell <= dwell_mem[idx_q];
        end
    end

    // Per-motor state. A write snaps the duty to the brake point when the
    // motor is being switched on from off, or switched off; re-targeting a
    // running motor leaves its duty where it is and lets the ramp proceed.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_MOTORS; i++) begin
                cur_mem[i]   <= '0;
                tgt_mem[i]   <= '0;
                dwell_mem[i] <= '0;
            end
            on_out <= '0;
        end else begin
            if ((state_q == ST_UPD) && !upd_blocked) begin
                cur_mem[idx_q]   <= upd_cur;
                dwell_mem[idx_q] <= upd_dwell;
            end
            if (wr_en && wr_addr_ok) begin
                tgt_mem[wr_addr] <= wr_tgt;
                on_out[wr_addr]  <= wr_on;
                if (!wr_on || !on_out[wr_addr]) begin
                    cur_mem[wr_addr]   <= half;
                    dwell_mem[wr_addr] <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mda_motor_control_ramp_sched.sv
// Self-checking bench for mda_motor_control_ramp_sched.
// Setup: NUM_MOTORS=8, TICK_DIV=32, period=1000, step=10, dwell_ticks=3.
module tb_mda_motor_control_ramp_sched;

    localparam int N      = 8;
    localparam int TDIV   = 32;
    localparam int BOUND  = 200;

    logic          clk;
    logic          reset;
    logic [15:0]   period;
    logic [15:0]   step;
    logic [7:0]    dwell_ticks;
    logic          wr_en;
    logic [2:0]    wr_addr;
    logic [15:0]   wr_data;
    logic          wr_on;
    logic [16*N-1:0] duty_out;
    logic [N-1:0]  on_out;
    logic          busy;

    int cmp_count;
    int err_count;

    mda_motor_control_ramp_sched #(
        .NUM_MOTORS (N),
        .TICK_DIV   (TDIV)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .period      (period),
        .step        (step),
        .dwell_ticks (dwell_ticks),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_on       (wr_on),
        .duty_out    (duty_out),
        .on_out      (on_out),
        .busy        (busy)
    );

    // Clock generation, 10 time-unit period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] duty(input int i);
        return duty_out[16*i +: 16];
    endfunction

    // Issue a one-cycle write command; returns at the negedge after it took effect
    task automatic do_write(input int addr, input int data, input logic on);
        wr_en   = 1'b1;
        wr_addr = 3'(addr);
        wr_data = 16'(data);
        wr_on   = on;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    // Wait for one complete scan (busy rise then fall), bounded
    task automatic wait_scan();
        int n;
        n = 0;
        while (busy !== 1'b1 && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        while (busy !== 1'b0 && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        if (n >= BOUND) begin
            cmp_count++;
            err_count++;
            $display("[TB] FAIL scan_timeout waited %0d cycles, limit %0d", n, BOUND);
        end
    endtask

    // Reset values and timing of the first scan
    task automatic test_reset();
        int k;
        int m;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        cmp_count++;
        if (duty_out !== '0) begin
            err_count++;
            $display("[TB] FAIL reset_duty got %h expected 0", duty_out);
        end
        cmp_count++;
        if (on_out !== '0) begin
            err_count++;
            $display("[TB] FAIL reset_on got %b expected 0", on_out);
        end
        cmp_count++;
        if (busy !== 1'b0) begin
            err_count++;
            $display("[TB] FAIL reset_busy got %b expected 0", busy);
        end
        reset = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (busy !== 1'b1 && k < 100);
        cmp_count++;
        if (k !== 32) begin
            err_count++;
            $display("[TB] FAIL first_busy_delay got %0d expected 32", k);
        end
        m = 0;
        while (busy === 1'b1 && m < 100) begin
            m++;
            @(negedge clk);
        end
        cmp_count++;
        if (m !== 16) begin
            err_count++;
            $display("[TB] FAIL busy_length got %0d expected 16", m);
        end
        // Motors that are off settle at the brake point after a scan
        cmp_count++;
        if (duty(5) !== 16'd500) begin
            err_count++;
            $display("[TB] FAIL off_motor_brake got %0d expected 500", duty(5));
        end
    endtask

    // Motor 0 switched on with target 600 ramps up by 10 per tick
    task automatic test_ramp_up();
        do_write(0, 600, 1'b1);
        cmp_count++;
        if (on_out[0] !== 1'b1) begin
            err_count++;
            $display("[TB] FAIL ramp_on got %b expected 1", on_out[0]);
        end
        cmp_count++;
        if (duty(0) !== 16'd500) begin
            err_count++;
            $display("[TB] FAIL ramp_snap got %0d expected 500", duty(0));
        end
        for (int t = 1; t <= 12; t++) begin
            int exp;
            wait_scan();
            exp = (t <= 10) ? 500 + 10 * t : 600;
            cmp_count++;
            if (duty(0) !== 16'(exp)) begin
                err_count++;
                $display("[TB] FAIL ramp_up_t%0d got %0d expected %0d", t, duty(0), exp);
            end
        end
    endtask

    // Retarget across the brake point: down to 500, hold 3 ticks, on to 400
    task automatic test_reversal();
        do_write(0, 400, 1'b1);
        cmp_count++;
        if (duty(0) !== 16'd600) begin
            err_count++;
            $display("[TB] FAIL reversal_no_snap got %0d expected 600", duty(0));
        end
        for (int t = 1; t <= 24; t++) begin
            int exp;
            wait_scan();
            if (t <= 10)
                exp = 600 - 10 * t;
            else if (t <= 13)
                exp = 500;
            else if (t <= 23)
                exp = 500 - 10 * (t - 13);
            else
                exp = 400;
            cmp_count++;
            if (duty(0) !== 16'(exp)) begin
                err_count++;
                $display("[TB] FAIL reversal_t%0d got %0d expected %0d", t, duty(0), exp);
            end
        end
    endtask

    // Motor 2 switched off mid-ramp brakes to half and stays there
    task automatic test_brake_off();
        do_write(2, 600, 1'b1);
        repeat (5) wait_scan();
        cmp_count++;
        if (duty(2) !== 16'd550) begin
            err_count++;
            $display("[TB] FAIL brake_pre got %0d expected 550", duty(2));
        end
        do_write(2, 600, 1'b0);
        cmp_count++;
        if (on_out[2] !== 1'b0) begin
            err_count++;
            $display("[TB] FAIL brake_on got %b expected 0", on_out[2]);
        end
        cmp_count++;
        if (duty(2) !== 16'd500) begin
            err_count++;
            $display("[TB] FAIL brake_snap got %0d expected 500", duty(2));
        end
        repeat (2) wait_scan();
        cmp_count++;
        if (duty(2) !== 16'd500) begin
            err_count++;
            $display("[TB] FAIL brake_hold got %0d expected 500", duty(2));
        end
    endtask

    // Write to motor 3 in the very cycle its update commits, then freeze with step=0
    task automatic test_write_during_upd();
        int n;
        do_write(3, 700, 1'b1);
        repeat (3) wait_scan();
        cmp_count++;
        if (duty(3) !== 16'd530) begin
            err_count++;
            $display("[TB] FAIL collide_pre got %0d expected 530", duty(3));
        end
        n = 0;
        while (busy !== 1'b1 && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        if (n >= BOUND) begin
            cmp_count++;
            err_count++;
            $display("[TB] FAIL collide_timeout waited %0d cycles", n);
        end
        // Scan started at the previous edge in RD(0); UPD(3) is 7 cycles later
        repeat (7) @(negedge clk);
        do_write(3, 300, 1'b1);
        cmp_count++;
        if (duty(3) !== 16'd530) begin
            err_count++;
            $display("[TB] FAIL collide_same_cycle got %0d expected 530", duty(3));
        end
        n = 0;
        while (busy !== 1'b0 && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        cmp_count++;
        if (duty(3) !== 16'd530) begin
            err_count++;
            $display("[TB] FAIL collide_after_scan got %0d expected 530", duty(3));
        end
        wait_scan();
        cmp_count++;
        if (duty(3) !== 16'd520) begin
            err_count++;
            $display("[TB] FAIL collide_new_target got %0d expected 520", duty(3));
        end
        step = 16'd0;
        repeat (2) wait_scan();
        cmp_count++;
        if (duty(3) !== 16'd520) begin
            err_count++;
            $display("[TB] FAIL step_zero_frozen got %0d expected 520", duty(3));
        end
        step = 16'd10;
    endtask

    // Target above period is clamped; lowering period clamps duty on next update
    task automatic test_clamp();
        int peak;
        peak = 0;
        do_write(1, 1200, 1'b1);
        cmp_count++;
        if (duty(1) !== 16'd500) begin
            err_count++;
            $display("[TB] FAIL clamp_snap got %0d expected 500", duty(1));
        end
        for (int t = 1; t <= 52; t++) begin
            wait_scan();
            if (int'(duty(1)) > peak)
                peak = int'(duty(1));
            if (t == 50) begin
                cmp_count++;
                if (duty(1) !== 16'd1000) begin
                    err_count++;
                    $display("[TB] FAIL clamp_reach got %0d expected 1000", duty(1));
                end
            end
        end
        cmp_count++;
        if (peak > 1000) begin
            err_count++;
            $display("[TB] FAIL clamp_peak got %0d expected at most 1000", peak);
        end
        cmp_count++;
        if (duty(1) !== 16'd1000) begin
            err_count++;
            $display("[TB] FAIL clamp_hold got %0d expected 1000", duty(1));
        end
        period = 16'd800;
        wait_scan();
        cmp_count++;
        if (duty(1) !== 16'd800) begin
            err_count++;
            $display("[TB] FAIL period_clamp got %0d expected 800", duty(1));
        end
        cmp_count++;
        if (duty(2) !== 16'd400) begin
            err_count++;
            $display("[TB] FAIL period_new_half got %0d expected 400", duty(2));
        end
        period = 16'd1000;
    endtask

    initial begin
        cmp_count   = 0;
        err_count   = 0;
        reset       = 1'b1;
        period      = 16'd1000;
        step        = 16'd10;
        dwell_ticks = 8'd3;
        wr_en       = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        wr_on       = 1'b0;
        @(negedge clk);
        test_reset();
        test_ramp_up();
        test_reversal();
        test_brake_off();
        test_write_during_upd();
        test_clamp();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
        $finish;
    end

endmodule
